fp_add_scheduler: RTL and testbench

FP_ADD_SCHEDULER -- requirements
Module: fp_add_scheduler

---
 rtl/fp_sched_pkg.sv | 26 ++
 rtl/fp_add_scheduler_arb.sv | 15 +
 rtl/fp_add_scheduler.sv | 157 +++++++++++++++
 tb/tb_fp_add_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// Shared types and defaults for the FP add scheduler: FSM states, widths,
// watchdog limit and the quiet-NaN pattern builder.
package fp_sched_pkg;

  localparam int MANT_DEF = 24;
  localparam int EXP_DEF  = 8;
  localparam int TMO_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Packed {sign, exp, frac}: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int mant_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i == mant_w - 2 || (i >= mant_w - 1 && i < mant_w - 1 + exp_w))
        v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/fp_add_scheduler_arb.sv
// Two-way round-robin arbiter: the requester named by pointer wins a tie.
module rr_arbiter2
  import fp_sched_pkg::*;
(
  input  logic [1:0] request,
  input  logic       pointer,
  output logic [1:0] grant,
  output logic       any
);

  assign any      = |request;
  assign grant[0] = request[0] & (~pointer | ~request[1]);
  assign grant[1] = request[1] & (pointer | ~request[0]);

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one FP adder/rounding pipeline between two requesters, one operation
// in flight. Define FP_SCHED_WATCHDOG_EN to add a BUSY-state timeout.
module fp_add_scheduler
  import fp_sched_pkg::*;
#(
  parameter int MANT = MANT_DEF,
  parameter int EXP  = EXP_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [1:0]          reqValid,
  output logic [1:0]          reqReady,
  input  logic [2*(EXP+MANT)-1:0] reqA,
  input  logic [2*(EXP+MANT)-1:0] reqB,
  input  logic [1:0]          reqSub,
  output logic [1:0]          respValid,
  input  logic [1:0]          respReady,
  output logic [EXP+MANT-1:0] respData,
  output logic                respInvalid,
  output logic [EXP+MANT-1:0] opA,
  output logic [EXP+MANT-1:0] opB,
  output logic                opSub,
  output logic                opValid,
  input  logic                unitValid,
  input  logic [MANT-1:0]     unitMant,
  input  logic [EXP-1:0]      unitExp,
  input  logic                unitSign,
  input  logic                unitInvalid,
  output logic                ResultValid
);

  localparam int W = EXP + MANT;

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           grant_q, grant_d;
  logic [W-1:0]   opA_q, opA_d, opB_q, opB_d;
  logic           opSub_q, opSub_d;
  logic [W-1:0]   respData_q, respData_d;
  logic           respInvalid_q, respInvalid_d;
  logic           pulse_q, pulse_d;
  logic [1:0]     arb_grant;
  logic           arb_any;
  logic           timeout;
  logic           unused_hidden;

  // The hidden bit is implied by the packed format and is dropped.
  assign unused_hidden = unitMant[MANT-1];

  rr_arbiter2 u_arb (
    .request (reqValid),
    .pointer (ptr_q),
    .grant   (arb_grant),
    .any     (arb_any)
  );

`ifdef FP_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(TMO) + 1;
  localparam logic [63:0]  QNAN_FULL = qnan_bits(EXP, MANT);
  localparam logic [W-1:0] QNAN      = QNAN_FULL[W-1:0];
  logic [CW-1:0] count_q, count_d;
  assign timeout = (count_q == CW'(TMO - 1));
`else
  localparam int unused_tmo = TMO;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b0;
      grant_q       <= 1'b0;
      opA_q         <= '0;
      opB_q         <= '0;
      opSub_q       <= 1'b0;
      respData_q    <= '0;
      respInvalid_q <= 1'b0;
      pulse_q       <= 1'b0;
`ifdef FP_SCHED_WATCHDOG_EN
      count_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      opA_q         <= opA_d;
      opB_q         <= opB_d;
      opSub_q       <= opSub_d;
      respData_q    <= respData_d;
      respInvalid_q <= respInvalid_d;
      pulse_q       <= pulse_d;
`ifdef FP_SCHED_WATCHDOG_EN
      count_q       <= count_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    opA_d         = opA_q;
    opB_d         = opB_q;
    opSub_d       = opSub_q;
    respData_d    = respData_q;
    respInvalid_d = respInvalid_q;
    pulse_d       = 1'b0;
`ifdef FP_SCHED_WATCHDOG_EN
    count_d       = (state_q == BUSY) ? count_q + 1'b1 : count_q;
`endif
    case (state_q)
      IDLE: if (arb_any) begin
        state_d = BUSY;
        grant_d = arb_grant[1];
        opA_d   = arb_grant[1] ? reqA[W +: W] : reqA[0 +: W];
        opB_d   = arb_grant[1] ? reqB[W +: W] : reqB[0 +: W];
        opSub_d = arb_grant[1] ? reqSub[1] : reqSub[0];
`ifdef FP_SCHED_WATCHDOG_EN
        count_d = '0;
`endif
      end
      BUSY: if (unitValid) begin
        state_d       = RESP;
        respData_d    = {unitSign, unitExp, unitMant[MANT-2:0]};
        respInvalid_d = unitInvalid;
        pulse_d       = 1'b1;
      end else if (timeout) begin
        state_d       = RESP;
`ifdef FP_SCHED_WATCHDOG_EN
        respData_d    = QNAN;
`endif
        respInvalid_d = 1'b1;
        pulse_d       = 1'b1;
      end
      RESP: if (respReady[grant_q]) begin
        state_d = IDLE;
        ptr_d   = ~grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (state_q == IDLE) ? arb_grant : 2'b00;
    opValid   = (state_q == BUSY);
    respValid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  end

  assign opA         = opA_q;
  assign opB         = opB_q;
  assign opSub       = opSub_q;
  assign respData    = respData_q;
  assign respInvalid = respInvalid_q;
  assign ResultValid = pulse_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler: expectations queued at stimulus time,
// a negedge monitor checks each delivered response against the queue.
module tb_fp_add_scheduler;

  localparam int MANT = 24;
  localparam int EXP  = 8;
  localparam int TMO  = 8;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [1:0]  reqValid, reqReady, reqSub, respValid, respReady;
  logic [63:0] reqA, reqB;
  logic [31:0] respData, opA, opB;
  logic        respInvalid, opSub, opValid, ResultValid;
  logic        unitValid, unitSign, unitInvalid;
  logic [23:0] unitMant;
  logic [7:0]  unitExp;

  typedef struct { int r; logic [31:0] d; logic inv; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int rv_pulses = 0;
  int cur_r = 0;

  fp_add_scheduler #(.MANT(MANT), .EXP(EXP), .TMO(TMO)) dut (
    .Clock(Clock), .Reset(Reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqA(reqA), .reqB(reqB),
    .reqSub(reqSub), .respValid(respValid), .respReady(respReady),
    .respData(respData), .respInvalid(respInvalid),
    .opA(opA), .opB(opB), .opSub(opSub), .opValid(opValid),
    .unitValid(unitValid), .unitMant(unitMant), .unitExp(unitExp),
    .unitSign(unitSign), .unitInvalid(unitInvalid), .ResultValid(ResultValid)
  );

  always #5 Clock = ~Clock;

  function automatic logic [1:0] mask(input int r);
    return (r != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (Reset) rv_pulses = 0;
    else begin
      if (ResultValid) rv_pulses++;
      if (|respValid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp actual=%b required=00", respValid);
        end else if ((respValid & respReady) != 2'b00) begin
          e = sb.pop_front();
          chk("mon_resp_valid", 64'(respValid), 64'(mask(e.r)));
          chk("mon_resp_data", 64'(respData), 64'(e.d));
          chk("mon_resp_invalid", 64'(respInvalid), 64'(e.inv));
          chk("mon_result_pulses", 64'(rv_pulses), 64'd1);
          rv_pulses = 0;
        end
      end
    end
  end

  task automatic do_reset;
    Reset = 1'b1; reqValid = '0; respReady = '0; unitValid = 1'b0;
    tick; tick;
    Reset = 1'b0;
  endtask

  // Presents rv, checks the grant goes to r, then checks the latched operands.
  task automatic accept(input logic [1:0] rv, input int r,
                        input logic [31:0] a, input logic [31:0] b, input logic sub);
    reqA[r*32 +: 32] = a;
    reqB[r*32 +: 32] = b;
    reqSub[r] = sub;
    reqValid = rv;
    @(negedge Clock);
    chk("req_ready", 64'(reqReady), 64'(mask(r)));
    tick;
    reqValid[r] = 1'b0;
    cur_r = r;
    @(negedge Clock);
    chk("op_valid", 64'(opValid), 64'd1);
    chk("op_a", 64'(opA), 64'(a));
    chk("op_b", 64'(opB), 64'(b));
    chk("op_sub", 64'(opSub), 64'(sub));
    tick;
  endtask

  task automatic unit_return(input int delay, input logic [31:0] d, input logic inv);
    repeat (delay) tick;
    unitValid = 1'b1;
    unitSign = d[31];
    unitExp = d[30:23];
    unitMant = {1'b1, d[22:0]};
    unitInvalid = inv;
    sb.push_back('{cur_r, d, inv});
    tick;
    unitValid = 1'b0;
    @(negedge Clock);
    chk("resp_latency", 64'(respValid), 64'(mask(cur_r)));
    tick;
  endtask

  task automatic consume(input int r);
    bit found;
    found = 1'b0;
    respReady[r] = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge Clock);
      if (respValid[r]) found = 1'b1;
    end
    if (!found) chk("resp_timeout", 64'd0, 64'd1);
    tick;
    respReady[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    Reset = 1'b1; reqValid = '0; respReady = '0; reqA = '0; reqB = '0; reqSub = '0;
    unitValid = 1'b0; unitSign = 1'b0; unitExp = '0; unitMant = '0; unitInvalid = 1'b0;
    tick; tick;
    @(negedge Clock);
    chk("rst_op_valid", 64'(opValid), 64'd0);
    chk("rst_resp_valid", 64'(respValid), 64'd0);
    chk("rst_resp_data", 64'(respData), 64'd0);
    tick;
    Reset = 1'b0;
    tick;

    // Single add: 1.0 + 2.0 = 3.0
    accept(2'b01, 0, 32'h3F800000, 32'h40000000, 1'b0);
    unit_return(2, 32'h40400000, 1'b0);
    consume(0);

    // Contention from reset: 0 first, 1 next, then 0 and 1 alternate
    do_reset;
    reqA[63:32] = 32'h40000000; reqB[63:32] = 32'h40400000;
    accept(2'b11, 0, 32'h40400000, 32'h3F800000, 1'b1);
    unit_return(1, 32'h40000000, 1'b0);
    consume(0);
    accept(2'b10, 1, 32'h40000000, 32'h40400000, 1'b0);
    unit_return(0, 32'h40A00000, 1'b0);
    consume(1);
    accept(2'b11, 0, 32'h3F800000, 32'h3F800000, 1'b0);
    unit_return(1, 32'h40000000, 1'b0);
    consume(0);
    accept(2'b10, 1, 32'h40A00000, 32'h40000000, 1'b1);
    unit_return(1, 32'h40400000, 1'b0);
    consume(1);

    // Backpressure with requester 1 waiting
    accept(2'b01, 0, 32'h3F800000, 32'h40000000, 1'b0);
    reqValid = 2'b10;
    unit_return(1, 32'h40400000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      chk("bp_resp_valid", 64'(respValid), 64'(2'b01));
      chk("bp_resp_data", 64'(respData), 64'h40400000);
      chk("bp_req_ready", 64'(reqReady), 64'd0);
      tick;
    end
    respReady[1] = 1'b1;
    @(negedge Clock);
    chk("bp_wrong_ready", 64'(respValid), 64'(2'b01));
    tick;
    respReady[1] = 1'b0;
    consume(0);

    // Invalid result delivered to requester 1
    accept(2'b10, 1, 32'h7F800000, 32'hFF800000, 1'b0);
    unit_return(1, 32'h7FC00000, 1'b1);
    consume(1);

    // Reset mid-BUSY; a late unit result must be dropped
    accept(2'b01, 0, 32'h3F800000, 32'h3F800000, 1'b1);
    Reset = 1'b1;
    tick;
    @(negedge Clock);
    chk("rb_op_valid", 64'(opValid), 64'd0);
    chk("rb_resp_valid", 64'(respValid), 64'd0);
    chk("rb_result_valid", 64'(ResultValid), 64'd0);
    chk("rb_req_ready", 64'(reqReady), 64'd0);
    chk("rb_op_a", 64'(opA), 64'd0);
    chk("rb_op_b", 64'(opB), 64'd0);
    chk("rb_op_sub", 64'(opSub), 64'd0);
    chk("rb_resp_data", 64'(respData), 64'd0);
    chk("rb_resp_invalid", 64'(respInvalid), 64'd0);
    tick;
    Reset = 1'b0;
    unitValid = 1'b1;
    tick;
    unitValid = 1'b0;
    repeat (5) tick;
    @(negedge Clock);
    chk("rb_no_resp", 64'(respValid), 64'd0);
    chk("rb_result_quiet", 64'(rv_pulses), 64'd0);
    tick;

    // Watchdog: unit stays silent
    accept(2'b01, 0, 32'h3F800000, 32'h40000000, 1'b0);
`ifdef FP_SCHED_WATCHDOG_EN
    sb.push_back('{0, 32'h7FC00000, 1'b1});
    n = 1;  // accept already spent one BUSY cycle
    while (n < 40) begin
      @(negedge Clock);
      if (respValid != 2'b00) break;
      n++;
    end
    chk("wd_busy_cycles", 64'(n), 64'(TMO));
    tick;
    consume(0);
`else
    n = 0;
    repeat (30) tick;
    @(negedge Clock);
    chk("wd_off_busy", 64'(opValid), 64'd1);
    chk("wd_off_no_resp", 64'(respValid), 64'd0);
    tick;
    do_reset;
`endif
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
